// File: rtl/frame_buf_ctrl_if.sv
// -----------------------------------------------------------------------------
// frame_buf_ctrl_if
// Bundles the scan enable, producer handshake and frame-mux select signals of
// the ping-pong frame buffer controller.
//
// Optional feature macro: FRAME_DROP_CNT_EN (adds DropCnt).
//
// Signals:
//   Enable     scan enable (to controller)
//   WrDone     producer finished filling the back buffer, 1-cycle pulse
//   WrBuf      buffer the producer may write (0 = Buf0, 1 = Buf1)
//   SwapAck    1-cycle pulse, front/back swap performed
//   SelBuf0    one-hot mux select: Buf0
//   SelBlank   one-hot mux select: blank
//   SelBuf1    one-hot mux select: Buf1
//   RdAddr     linear read address into the front buffer
//   HCnt/VCnt  raster position of the current pixel
//   FrameStart high on pixel (0,0) while scanning
//   Overrun    sticky producer protocol error
//   DropCnt    repeated-frame counter (FRAME_DROP_CNT_EN only)
//
// Modports: master = producer/display side, slave = controller.
// -----------------------------------------------------------------------------
interface frame_buf_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              Enable;
  logic              WrDone;
  logic              WrBuf;
  logic              SwapAck;
  logic              SelBuf0;
  logic              SelBlank;
  logic              SelBuf1;
  logic [ADDR_W-1:0] RdAddr;
  logic [15:0]       HCnt;
  logic [15:0]       VCnt;
  logic              FrameStart;
  logic              Overrun;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0]       DropCnt;

  modport master (
    output Enable, WrDone,
    input  WrBuf, SwapAck, SelBuf0, SelBlank, SelBuf1, RdAddr,
    input  HCnt, VCnt, FrameStart, Overrun, DropCnt
  );

  modport slave (
    input  Enable, WrDone,
    output WrBuf, SwapAck, SelBuf0, SelBlank, SelBuf1, RdAddr,
    output HCnt, VCnt, FrameStart, Overrun, DropCnt
  );
`else
  modport master (
    output Enable, WrDone,
    input  WrBuf, SwapAck, SelBuf0, SelBlank, SelBuf1, RdAddr,
    input  HCnt, VCnt, FrameStart, Overrun
  );

  modport slave (
    input  Enable, WrDone,
    output WrBuf, SwapAck, SelBuf0, SelBlank, SelBuf1, RdAddr,
    output HCnt, VCnt, FrameStart, Overrun
  );
`endif
endinterface

// File: rtl/frame_buf_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buf_ctrl
// Ping-pong (double buffer) scan controller. Generates the raster counters,
// the linear read address into the front buffer and the one-hot select for
// the frame multiplexer. Front/back buffers swap only on the edge that starts
// a new frame, so a frame is never torn.
//
// Optional feature macro: FRAME_DROP_CNT_EN
//   When defined, bus.DropCnt counts (saturating) frame boundaries at which
//   no new buffer was ready, i.e. the front buffer was shown again.
//
// Ports:
//   Clk    pixel clock, rising edge
//   Rst_n  asynchronous active-low reset
//   bus    frame_buf_ctrl_if.slave (handshake, selects, counters, address)
//
// All outputs are registered and describe the same pixel in the same cycle.
// -----------------------------------------------------------------------------
module frame_buf_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 19
) (
  input  logic            Clk,
  input  logic            Rst_n,
  frame_buf_ctrl_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [15:0]       H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0]       V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0]       H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0]       V_ACT    = 16'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_r;
  logic [15:0]       h_cnt_r;
  logic [15:0]       v_cnt_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              disp_buf_r;
  logic              wr_buf_r;
  logic              pending_r;
  logic              swap_ack_r;
  logic              overrun_r;
  logic              frame_start_r;
  logic              sel_buf0_r;
  logic              sel_blank_r;
  logic              sel_buf1_r;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0]       drop_cnt_r;
`endif

  logic        h_last_s;
  logic        v_last_s;
  logic        frame_end_s;
  logic [15:0] h_next_s;
  logic [15:0] v_next_s;
  logic        cur_active_s;
  logic        next_active_s;
  logic        swap_s;
  logic        repeat_s;
  logic        disp_next_s;
  logic        pending_next_s;

  // Next raster position, active-region decode and frame-boundary swap decision
  always_comb begin
    h_last_s       = (h_cnt_r == H_LAST);
    v_last_s       = (v_cnt_r == V_LAST);
    frame_end_s    = h_last_s & v_last_s;
    h_next_s       = h_last_s ? 16'd0 : (h_cnt_r + 16'd1);
    v_next_s       = h_last_s ? (v_last_s ? 16'd0 : (v_cnt_r + 16'd1)) : v_cnt_r;
    cur_active_s   = (h_cnt_r < H_ACT) & (v_cnt_r < V_ACT);
    next_active_s  = (h_next_s < H_ACT) & (v_next_s < V_ACT);
    // A boundary only counts while scanning continues; dropping Enable on the
    // last clock abandons the frame without swapping.
    swap_s         = (state_r == ST_SCAN) & bus.Enable & frame_end_s & pending_r;
    repeat_s       = (state_r == ST_SCAN) & bus.Enable & frame_end_s & ~pending_r;
    disp_next_s    = disp_buf_r ^ swap_s;
    // A WrDone landing on the swap edge re-arms Pending for the next boundary.
    pending_next_s = swap_s ? bus.WrDone : (pending_r | bus.WrDone);
  end

  // Scan state machine with all registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r       <= ST_IDLE;
      h_cnt_r       <= 16'd0;
      v_cnt_r       <= 16'd0;
      rd_addr_r     <= '0;
      disp_buf_r    <= 1'b0;
      wr_buf_r      <= 1'b1;
      pending_r     <= 1'b0;
      swap_ack_r    <= 1'b0;
      overrun_r     <= 1'b0;
      frame_start_r <= 1'b0;
      sel_buf0_r    <= 1'b0;
      sel_blank_r   <= 1'b1;
      sel_buf1_r    <= 1'b0;
`ifdef FRAME_DROP_CNT_EN
      drop_cnt_r    <= 16'd0;
`endif
    end else begin
      // Handshake bookkeeping runs in every state, including IDLE.
      pending_r  <= pending_next_s;
      overrun_r  <= overrun_r | (bus.WrDone & pending_r);
      swap_ack_r <= swap_s;
      disp_buf_r <= disp_next_s;
      wr_buf_r   <= ~disp_next_s;
`ifdef FRAME_DROP_CNT_EN
      if (repeat_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
`endif

      case (state_r)
        ST_IDLE: begin
          h_cnt_r   <= 16'd0;
          v_cnt_r   <= 16'd0;
          rd_addr_r <= '0;
          if (bus.Enable) begin
            // Pixel (0,0) is always active, so it shows the front buffer.
            state_r       <= ST_SCAN;
            frame_start_r <= 1'b1;
            sel_buf0_r    <= ~disp_buf_r;
            sel_buf1_r    <= disp_buf_r;
            sel_blank_r   <= 1'b0;
          end else begin
            state_r       <= ST_IDLE;
            frame_start_r <= 1'b0;
            sel_buf0_r    <= 1'b0;
            sel_buf1_r    <= 1'b0;
            sel_blank_r   <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (!bus.Enable) begin
            state_r       <= ST_IDLE;
            h_cnt_r       <= 16'd0;
            v_cnt_r       <= 16'd0;
            rd_addr_r     <= '0;
            frame_start_r <= 1'b0;
            sel_buf0_r    <= 1'b0;
            sel_buf1_r    <= 1'b0;
            sel_blank_r   <= 1'b1;
          end else begin
            state_r       <= ST_SCAN;
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            frame_start_r <= frame_end_s;
            // The address advances after each active pixel and parks during
            // blanking, which yields VCnt*H_ACTIVE+HCnt on every active pixel.
            if (frame_end_s) begin
              rd_addr_r <= '0;
            end else if (cur_active_s) begin
              rd_addr_r <= rd_addr_r + ADDR_ONE;
            end else begin
              rd_addr_r <= rd_addr_r;
            end
            sel_buf0_r    <= next_active_s & ~disp_next_s;
            sel_buf1_r    <= next_active_s & disp_next_s;
            sel_blank_r   <= ~next_active_s;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          h_cnt_r       <= 16'd0;
          v_cnt_r       <= 16'd0;
          rd_addr_r     <= '0;
          frame_start_r <= 1'b0;
          sel_buf0_r    <= 1'b0;
          sel_buf1_r    <= 1'b0;
          sel_blank_r   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.HCnt       = h_cnt_r;
  assign bus.VCnt       = v_cnt_r;
  assign bus.RdAddr     = rd_addr_r;
  assign bus.WrBuf      = wr_buf_r;
  assign bus.SwapAck    = swap_ack_r;
  assign bus.Overrun    = overrun_r;
  assign bus.FrameStart = frame_start_r;
  assign bus.SelBuf0    = sel_buf0_r;
  assign bus.SelBlank   = sel_blank_r;
  assign bus.SelBuf1    = sel_buf1_r;
`ifdef FRAME_DROP_CNT_EN
  assign bus.DropCnt    = drop_cnt_r;
`endif

endmodule
